// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-ported data memory.
// The slave view is the arbiter; the master view is the requesters plus the memory.
interface dm_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [2:0]  p0_funct3;
  logic [9:0]  p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic [31:0] p0_rdata;
  logic        p0_rvalid;

  logic        p1_req;
  logic        p1_we;
  logic [2:0]  p1_funct3;
  logic [9:0]  p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_lock;
  logic        p1_gnt;
  logic [31:0] p1_rdata;
  logic        p1_rvalid;

  logic [3:0]  dm_wea;
  logic [9:0]  dm_addra;
  logic [31:0] dm_dina;
  logic [31:0] dm_douta;

  modport slave (
    input  p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_funct3, p1_addr, p1_wdata, p1_lock,
    input  dm_douta,
    output p0_gnt, p0_rdata, p0_rvalid,
    output p1_gnt, p1_rdata, p1_rvalid,
    output dm_wea, dm_addra, dm_dina
  );

  modport master (
    output p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_funct3, p1_addr, p1_wdata, p1_lock,
    output dm_douta,
    input  p0_gnt, p0_rdata, p0_rvalid,
    input  p1_gnt, p1_rdata, p1_rvalid,
    input  dm_wea, dm_addra, dm_dina
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the byte-addressed data memory: one access per cycle,
// bounded port-1 starvation, capped port-1 burst lock, load sizing and extension.
module dm_arbiter #(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  dm_arbiter_if.slave  bus
);

  localparam logic [3:0] LpMaxWait  = 4'(MAX_WAIT);
  localparam logic [3:0] LpBurstMax = 4'(BURST_MAX);

  typedef enum logic [1:0] {SelIdle, SelP0, SelP1} sel_e;

  logic [3:0]  r_wait_cnt;
  logic [3:0]  r_burst_cnt;
  logic        r_p1_last;
  logic [31:0] r_p0_rdata;
  logic [31:0] r_p1_rdata;
  logic        r_p0_rvalid;
  logic        r_p1_rvalid;

  sel_e        w_sel;
  logic        w_lock;
  logic        w_starved;
  logic        w_p0_gnt;
  logic        w_p1_gnt;
  logic        w_we;
  logic [2:0]  w_funct3;
  logic [9:0]  w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;

  function automatic logic [3:0] f_store_mask(input logic [1:0] size);
    case (size)
      2'b00:   f_store_mask = 4'b0001;
      2'b01:   f_store_mask = 4'b0011;
      2'b10:   f_store_mask = 4'b1111;
      default: f_store_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] f_load_ext(input logic [2:0] funct3, input logic [31:0] d);
    case (funct3[1:0])
      2'b00:   f_load_ext = funct3[2] ? {24'h0, d[7:0]}   : {{24{d[7]}}, d[7:0]};
      2'b01:   f_load_ext = funct3[2] ? {16'h0, d[15:0]}  : {{16{d[15]}}, d[15:0]};
      2'b10:   f_load_ext = d;
      default: f_load_ext = 32'h0;
    endcase
  endfunction

  assign w_lock    = bus.p1_req && bus.p1_lock && r_p1_last && (r_burst_cnt < LpBurstMax);
  assign w_starved = bus.p1_req && (r_wait_cnt == LpMaxWait);

  // Reset forces the idle selection so no grant or memory write leaks out while held.
  always_comb begin
    w_sel = SelIdle;
    if (rst) begin
      w_sel = SelIdle;
    end else if (w_lock || w_starved) begin
      w_sel = SelP1;
    end else if (bus.p0_req) begin
      w_sel = SelP0;
    end else if (bus.p1_req) begin
      w_sel = SelP1;
    end
  end

  always_comb begin
    w_we     = 1'b0;
    w_funct3 = 3'b000;
    w_addr   = 10'h000;
    w_wdata  = 32'h0;
    unique case (w_sel)
      SelP0: begin
        w_we     = bus.p0_we;
        w_funct3 = bus.p0_funct3;
        w_addr   = bus.p0_addr;
        w_wdata  = bus.p0_wdata;
      end
      SelP1: begin
        w_we     = bus.p1_we;
        w_funct3 = bus.p1_funct3;
        w_addr   = bus.p1_addr;
        w_wdata  = bus.p1_wdata;
      end
      default: ;
    endcase
  end

  assign w_p0_gnt  = (w_sel == SelP0);
  assign w_p1_gnt  = (w_sel == SelP1);
  assign w_ld_data = f_load_ext(w_funct3, bus.dm_douta);

  assign bus.p0_gnt    = w_p0_gnt;
  assign bus.p1_gnt    = w_p1_gnt;
  assign bus.dm_wea    = w_we ? f_store_mask(w_funct3[1:0]) : 4'b0000;
  assign bus.dm_addra  = w_addr;
  assign bus.dm_dina   = w_wdata;
  assign bus.p0_rdata  = r_p0_rdata;
  assign bus.p1_rdata  = r_p1_rdata;
  assign bus.p0_rvalid = r_p0_rvalid;
  assign bus.p1_rvalid = r_p1_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt  <= 4'h0;
      r_burst_cnt <= 4'h0;
      r_p1_last   <= 1'b0;
      r_p0_rdata  <= 32'h0;
      r_p1_rdata  <= 32'h0;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
    end else begin
      r_p1_last <= w_p1_gnt;

      if (bus.p1_req && !w_p1_gnt) begin
        if (r_wait_cnt < LpMaxWait) begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
        end
      end else begin
        r_wait_cnt <= 4'h0;
      end

      if (w_p1_gnt) begin
        if (r_burst_cnt != 4'hF) begin
          r_burst_cnt <= r_burst_cnt + 4'd1;
        end
      end else begin
        r_burst_cnt <= 4'h0;
      end

      // The memory reads combinationally, so load data is captured at the end of the grant.
      r_p0_rvalid <= w_p0_gnt && !w_we;
      r_p1_rvalid <= w_p1_gnt && !w_we;
      if (w_p0_gnt && !w_we) begin
        r_p0_rdata <= w_ld_data;
      end
      if (w_p1_gnt && !w_we) begin
        r_p1_rdata <= w_ld_data;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural 1 KiB byte memory.
module tb_dm_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  dm_arbiter_if bus ();

  dm_arbiter #(
    .MAX_WAIT  (4),
    .BURST_MAX (8)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: byte writes at the clock edge, combinational wrapped read.
  logic [7:0] mem [1024];
  logic [9:0] w_a0, w_a1, w_a2, w_a3;

  always_comb begin
    w_a0 = bus.dm_addra;
    w_a1 = bus.dm_addra + 10'd1;
    w_a2 = bus.dm_addra + 10'd2;
    w_a3 = bus.dm_addra + 10'd3;
    bus.dm_douta = {mem[w_a3], mem[w_a2], mem[w_a1], mem[w_a0]};
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bus.dm_wea[b]) mem[bus.dm_addra + 10'(b)] <= bus.dm_dina[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic        p0_req;
    logic        p0_we;
    logic [2:0]  p0_f3;
    logic [9:0]  p0_addr;
    logic [31:0] p0_wdata;
    logic        p1_req;
    logic        p1_we;
    logic [2:0]  p1_f3;
    logic [9:0]  p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_lock;
    logic        e_g0;
    logic        e_g1;
    logic [3:0]  e_wea;
    logic [9:0]  e_addr;
    logic [31:0] e_din;
    logic        e_rv0;
    logic        e_rv1;
    logic [31:0] e_rd;
  } vec_t;

  localparam int NumVec = 25;
  vec_t tbl [NumVec];
  logic [31:0] exp_rd0;
  logic [31:0] exp_rd1;

  function automatic vec_t mk_p0(input logic we, input logic [2:0] f3, input logic [9:0] a,
                                 input logic [31:0] wd, input logic [3:0] wea,
                                 input logic rv, input logic [31:0] rd);
    vec_t v = '{default: '0};
    v.p0_req = 1'b1; v.p0_we = we; v.p0_f3 = f3; v.p0_addr = a; v.p0_wdata = wd;
    v.e_g0 = 1'b1; v.e_wea = wea; v.e_addr = a; v.e_din = wd; v.e_rv0 = rv; v.e_rd = rd;
    return v;
  endfunction

  function automatic vec_t mk_p1(input logic we, input logic [2:0] f3, input logic [9:0] a,
                                 input logic [31:0] wd, input logic [3:0] wea,
                                 input logic rv, input logic [31:0] rd);
    vec_t v = '{default: '0};
    v.p1_req = 1'b1; v.p1_we = we; v.p1_f3 = f3; v.p1_addr = a; v.p1_wdata = wd;
    v.e_g1 = 1'b1; v.e_wea = wea; v.e_addr = a; v.e_din = wd; v.e_rv1 = rv; v.e_rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic set_p0(input logic req, input logic we, input logic [2:0] f3,
                        input logic [9:0] a, input logic [31:0] wd);
    bus.p0_req = req; bus.p0_we = we; bus.p0_funct3 = f3; bus.p0_addr = a; bus.p0_wdata = wd;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic [2:0] f3,
                        input logic [9:0] a, input logic [31:0] wd, input logic lock);
    bus.p1_req = req; bus.p1_we = we; bus.p1_funct3 = f3; bus.p1_addr = a; bus.p1_wdata = wd;
    bus.p1_lock = lock;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    set_p0(1'b0, 1'b0, 3'b000, 10'h000, 32'h0);
    set_p1(1'b0, 1'b0, 3'b000, 10'h000, 32'h0, 1'b0);
    @(posedge clk);
  endtask

  task automatic apply_vec(input int i);
    vec_t v = tbl[i];
    @(negedge clk);
    set_p0(v.p0_req, v.p0_we, v.p0_f3, v.p0_addr, v.p0_wdata);
    set_p1(v.p1_req, v.p1_we, v.p1_f3, v.p1_addr, v.p1_wdata, v.p1_lock);
    #2;
    chk($sformatf("v%0d p0_gnt", i), 32'(bus.p0_gnt), 32'(v.e_g0));
    chk($sformatf("v%0d p1_gnt", i), 32'(bus.p1_gnt), 32'(v.e_g1));
    chk($sformatf("v%0d dm_wea", i), 32'(bus.dm_wea), 32'(v.e_wea));
    chk($sformatf("v%0d dm_addra", i), 32'(bus.dm_addra), 32'(v.e_addr));
    chk($sformatf("v%0d dm_dina", i), bus.dm_dina, v.e_din);
    @(posedge clk);
    #1;
    if (v.e_rv0) exp_rd0 = v.e_rd;
    if (v.e_rv1) exp_rd1 = v.e_rd;
    chk($sformatf("v%0d p0_rvalid", i), 32'(bus.p0_rvalid), 32'(v.e_rv0));
    chk($sformatf("v%0d p1_rvalid", i), 32'(bus.p1_rvalid), 32'(v.e_rv1));
    chk($sformatf("v%0d p0_rdata", i), bus.p0_rdata, exp_rd0);
    chk($sformatf("v%0d p1_rdata", i), bus.p1_rdata, exp_rd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_g1;
    int   p1_done;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    set_p0(1'b1, 1'b0, 3'b010, 10'h010, 32'h1);
    set_p1(1'b1, 1'b1, 3'b010, 10'h020, 32'h2, 1'b1);

    tbl[0]  = mk_p0(1'b1, 3'b010, 10'h010, 32'h8000_00FF, 4'b1111, 1'b0, 32'h0);
    tbl[1]  = mk_p0(1'b0, 3'b010, 10'h010, 32'h0,         4'b0000, 1'b1, 32'h8000_00FF);
    tbl[2]  = mk_p0(1'b1, 3'b000, 10'h013, 32'h0000_00AB, 4'b0001, 1'b0, 32'h0);
    tbl[3]  = mk_p0(1'b0, 3'b000, 10'h013, 32'h0,         4'b0000, 1'b1, 32'hFFFF_FFAB);
    tbl[4]  = mk_p0(1'b0, 3'b100, 10'h013, 32'h0,         4'b0000, 1'b1, 32'h0000_00AB);
    tbl[5]  = mk_p0(1'b1, 3'b010, 10'h010, 32'h1234_8765, 4'b1111, 1'b0, 32'h0);
    tbl[6]  = mk_p0(1'b0, 3'b001, 10'h012, 32'h0,         4'b0000, 1'b1, 32'h0000_1234);
    tbl[7]  = mk_p0(1'b0, 3'b101, 10'h012, 32'h0,         4'b0000, 1'b1, 32'h0000_1234);
    tbl[8]  = mk_p0(1'b0, 3'b001, 10'h010, 32'h0,         4'b0000, 1'b1, 32'hFFFF_8765);
    tbl[9]  = mk_p0(1'b0, 3'b101, 10'h010, 32'h0,         4'b0000, 1'b1, 32'h0000_8765);
    tbl[10] = mk_p1(1'b1, 3'b001, 10'h020, 32'hCAFE_BEEF, 4'b0011, 1'b0, 32'h0);
    tbl[11] = mk_p1(1'b0, 3'b010, 10'h020, 32'h0,         4'b0000, 1'b1, 32'h0000_BEEF);
    tbl[12] = mk_p1(1'b0, 3'b000, 10'h020, 32'h0,         4'b0000, 1'b1, 32'hFFFF_FFEF);
    tbl[13] = mk_p0(1'b0, 3'b011, 10'h010, 32'h0,         4'b0000, 1'b1, 32'h0);
    tbl[14] = mk_p0(1'b1, 3'b011, 10'h010, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0);
    tbl[15] = mk_p0(1'b0, 3'b010, 10'h010, 32'h0,         4'b0000, 1'b1, 32'h1234_8765);
    tbl[16] = mk_p0(1'b1, 3'b000, 10'h3FE, 32'h0000_0011, 4'b0001, 1'b0, 32'h0);
    tbl[17] = mk_p0(1'b1, 3'b000, 10'h3FF, 32'h0000_0022, 4'b0001, 1'b0, 32'h0);
    tbl[18] = mk_p1(1'b1, 3'b000, 10'h000, 32'h0000_0033, 4'b0001, 1'b0, 32'h0);
    tbl[19] = mk_p1(1'b1, 3'b100, 10'h001, 32'h0000_0044, 4'b0001, 1'b0, 32'h0);
    tbl[20] = mk_p0(1'b0, 3'b010, 10'h3FE, 32'h0,         4'b0000, 1'b1, 32'h4433_2211);
    // Idle with junk on the address/data fields: the memory bus must read all zero.
    tbl[21] = '{default: '0};
    tbl[21].p0_addr = 10'h155; tbl[21].p0_wdata = 32'h5555_5555;
    tbl[21].p1_addr = 10'h2AA; tbl[21].p1_wdata = 32'hAAAA_AAAA; tbl[21].p0_we = 1'b1;
    // Both requesting, port 1 not starved: port 0 wins with its own fields.
    tbl[22] = mk_p0(1'b0, 3'b010, 10'h010, 32'h0BAD_F00D, 4'b0000, 1'b1, 32'h1234_8765);
    tbl[22].p1_req = 1'b1; tbl[22].p1_we = 1'b1; tbl[22].p1_f3 = 3'b010;
    tbl[22].p1_addr = 10'h030; tbl[22].p1_wdata = 32'h5A5A_5A5A;
    tbl[23] = '{default: '0};
    tbl[24] = mk_p1(1'b0, 3'b101, 10'h3FE, 32'h0,         4'b0000, 1'b1, 32'h0000_2211);

    // Reset state with both ports requesting.
    repeat (2) @(posedge clk);
    #1;
    chk("rst p0_gnt", 32'(bus.p0_gnt), 32'h0);
    chk("rst p1_gnt", 32'(bus.p1_gnt), 32'h0);
    chk("rst dm_wea", 32'(bus.dm_wea), 32'h0);
    chk("rst dm_addra", 32'(bus.dm_addra), 32'h0);
    chk("rst dm_dina", bus.dm_dina, 32'h0);
    chk("rst p0_rdata", bus.p0_rdata, 32'h0);
    chk("rst p1_rdata", bus.p1_rdata, 32'h0);
    chk("rst p0_rvalid", 32'(bus.p0_rvalid), 32'h0);
    chk("rst p1_rvalid", 32'(bus.p1_rvalid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_p0(1'b0, 1'b0, 3'b000, 10'h000, 32'h0);
    set_p1(1'b0, 1'b0, 3'b000, 10'h000, 32'h0, 1'b0);
    exp_rd0 = 32'h0;
    exp_rd1 = 32'h0;

    for (int i = 0; i < NumVec; i++) apply_vec(i);

    // Starvation: both held, no lock; port 1 forced in every fifth cycle.
    idle_cycle();
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      set_p0(1'b1, 1'b0, 3'b010, 10'h010, 32'h0);
      set_p1(1'b1, 1'b0, 3'b010, 10'h020, 32'h0, 1'b0);
      exp_g1 = (c % 5 == 0);
      #2;
      chk($sformatf("starve c%0d p1_gnt", c), 32'(bus.p1_gnt), 32'(exp_g1));
      chk($sformatf("starve c%0d p0_gnt", c), 32'(bus.p0_gnt), 32'(!exp_g1));
      @(posedge clk);
    end

    // Locked burst of 12: 8 port-1 grants, port 0 for 4 cycles, then port 1 again.
    idle_cycle();
    p1_done = 0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      set_p0(c >= 2, 1'b0, 3'b010, 10'h010, 32'h0);
      set_p1(p1_done < 12, 1'b0, 3'b010, 10'h020, 32'h0, 1'b1);
      exp_g1 = (c <= 8) || (c >= 13 && c <= 16);
      #2;
      chk($sformatf("burst c%0d p1_gnt", c), 32'(bus.p1_gnt), 32'(exp_g1));
      chk($sformatf("burst c%0d p0_gnt", c), 32'(bus.p0_gnt), 32'(!exp_g1));
      if (exp_g1) p1_done++;
      @(posedge clk);
    end

    // Reset in the cycle of a granted load, with requests held across it.
    idle_cycle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      set_p0(1'b1, 1'b0, 3'b010, 10'h010, 32'h0);
      set_p1(1'b1, 1'b0, 3'b010, 10'h020, 32'h0, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    #2;
    chk("mrst pre p0_gnt", 32'(bus.p0_gnt), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst p0_gnt", 32'(bus.p0_gnt), 32'h0);
    chk("mrst p1_gnt", 32'(bus.p1_gnt), 32'h0);
    chk("mrst dm_wea", 32'(bus.dm_wea), 32'h0);
    chk("mrst dm_addra", 32'(bus.dm_addra), 32'h0);
    chk("mrst dm_dina", bus.dm_dina, 32'h0);
    chk("mrst p0_rdata", bus.p0_rdata, 32'h0);
    @(posedge clk);
    #1;
    chk("mrst p0_rvalid", 32'(bus.p0_rvalid), 32'h0);
    chk("mrst p0_rdata edge", bus.p0_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #2;
      chk($sformatf("post c%0d p1_gnt", c), 32'(bus.p1_gnt), 32'(c == 5));
      chk($sformatf("post c%0d p0_gnt", c), 32'(bus.p0_gnt), 32'(c != 5));
      @(posedge clk);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
